// File: rtl/ipa_cfg_launcher.sv
// Launches one IPA job over the config bus: write COMMAND, poll STATUS until bit 0
// is set, clear STATUS, then pulse done (or pulse error on timeout / ID mismatch).
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for start
// CMD_REQ  | write of cmd to COMMAND presented, waiting for gnt
// CMD_RSP  | COMMAND write granted, waiting for valid
// POLL_REQ | STATUS read presented, waiting for gnt
// POLL_RSP | STATUS read granted, waiting for valid
// GAP      | idle spacing between STATUS polls
// CLR_REQ  | write of 0 to STATUS presented, waiting for gnt
// CLR_RSP  | STATUS clear granted, waiting for valid
module ipa_cfg_launcher #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    BE_WIDTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    POLL_GAP    = 8,
  parameter int                    MAX_POLLS   = 1024,
  parameter int                    RSP_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cmd,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic                  m_ipa_cfg_req,
  output logic [ADDR_WIDTH-1:0] m_ipa_cfg_add,
  output logic                  m_ipa_cfg_wen,
  output logic [DATA_WIDTH-1:0] m_ipa_cfg_wdata,
  output logic [BE_WIDTH-1:0]   m_ipa_cfg_be,
  output logic [4:0]            m_ipa_cfg_id,
  input  logic                  m_ipa_cfg_gnt,
  input  logic [DATA_WIDTH-1:0] m_ipa_cfg_rdata,
  input  logic                  m_ipa_cfg_valid,
  input  logic [4:0]            m_ipa_cfg_r_id
);

  localparam int GAP_W  = $clog2(POLL_GAP) + 1;
  localparam int RSP_W  = $clog2(RSP_TIMEOUT) + 1;
  localparam int POLL_W = $clog2(MAX_POLLS + 1);

  localparam logic [ADDR_WIDTH-1:0] CMD_ADDR    = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + ADDR_WIDTH'(4);

  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(POLL_GAP - 1);
  localparam logic [RSP_W-1:0]  RSP_LOAD = RSP_W'(RSP_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(MAX_POLLS);

  localparam logic [1:0] ERR_POLL = 2'b01;
  localparam logic [1:0] ERR_ID   = 2'b10;
  localparam logic [1:0] ERR_RSP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD_REQ,
    CMD_RSP,
    POLL_REQ,
    POLL_RSP,
    GAP,
    CLR_REQ,
    CLR_RSP
  } state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] add_q, add_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            id_q, id_d;
  logic [4:0]            issued_q, issued_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [POLL_W-1:0]     poll_q, poll_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [RSP_W-1:0]      rsp_q, rsp_d;

  logic                  abort;
  logic [1:0]            abort_code;
  logic                  launch_rd;
  logic                  launch_clr;

  // Only the STATUS ready flag is consumed from read data.
  logic                  unused_rdata;
  assign unused_rdata = ^m_ipa_cfg_rdata[DATA_WIDTH-1:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      add_q      <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      id_q       <= '0;
      issued_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      poll_q     <= '0;
      gap_q      <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      add_q      <= add_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      id_q       <= id_d;
      issued_q   <= issued_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      poll_q     <= poll_d;
      gap_q      <= gap_d;
      rsp_q      <= rsp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    add_d      = add_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    id_d       = id_q;
    issued_d   = issued_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    rsp_d      = rsp_q;
    abort      = 1'b0;
    abort_code = 2'b00;
    launch_rd  = 1'b0;
    launch_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CMD_REQ;
          req_d      = 1'b1;
          add_d      = CMD_ADDR;
          wen_d      = 1'b0;
          wdata_d    = cmd;
          busy_d     = 1'b1;
          err_code_d = 2'b00;
          poll_d     = '0;
        end
      end

      CMD_REQ, POLL_REQ, CLR_REQ: begin
        if (req_q && m_ipa_cfg_gnt) begin
          req_d    = 1'b0;
          issued_d = id_q;
          id_d     = id_q + 5'd1;
          rsp_d    = RSP_LOAD;
          state_d  = (state_q == CMD_REQ)  ? CMD_RSP  :
                     (state_q == POLL_REQ) ? POLL_RSP : CLR_RSP;
          if (state_q == POLL_REQ) poll_d = poll_q + POLL_W'(1);
        end
      end

      CMD_RSP, POLL_RSP, CLR_RSP: begin
        if (m_ipa_cfg_valid) begin
          if (m_ipa_cfg_r_id != issued_q) begin
            abort      = 1'b1;
            abort_code = ERR_ID;
          end else if (state_q == CMD_RSP) begin
            launch_rd = 1'b1;
          end else if (state_q == CLR_RSP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (m_ipa_cfg_rdata[0]) begin
            launch_clr = 1'b1;
          end else if (poll_q == POLL_MAX) begin
            abort      = 1'b1;
            abort_code = ERR_POLL;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end else if (rsp_q == '0) begin
          abort      = 1'b1;
          abort_code = ERR_RSP;
        end else begin
          rsp_d = rsp_q - RSP_W'(1);
        end
      end

      GAP: begin
        if (gap_q == '0) launch_rd = 1'b1;
        else             gap_d     = gap_q - GAP_W'(1);
      end

      default: state_d = IDLE;
    endcase

    if (launch_rd) begin
      state_d = POLL_REQ;
      req_d   = 1'b1;
      add_d   = STATUS_ADDR;
      wen_d   = 1'b1;
      wdata_d = '0;
    end

    if (launch_clr) begin
      state_d = CLR_REQ;
      req_d   = 1'b1;
      add_d   = STATUS_ADDR;
      wen_d   = 1'b0;
      wdata_d = '0;
    end

    // An abort never issues the STATUS clear; the job is simply dropped.
    if (abort) begin
      state_d    = IDLE;
      req_d      = 1'b0;
      busy_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = abort_code;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign m_ipa_cfg_req   = req_q;
  assign m_ipa_cfg_add   = add_q;
  assign m_ipa_cfg_wen   = wen_q;
  assign m_ipa_cfg_wdata = wdata_q;
  assign m_ipa_cfg_be    = '1;
  assign m_ipa_cfg_id    = id_q;

endmodule
